// File: rtl/mdu_div_pkg.sv
// Shared core definitions for the multi-cycle divider: FSM encodings,
// start/ready handshake levels and the stall encodings also used by the
// pipeline stall controller.
package mdu_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ZERO = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    localparam logic DIV_START     = 1'b1;
    localparam logic DIV_STOP      = 1'b0;
    localparam logic DIV_READY     = 1'b1;
    localparam logic DIV_NOT_READY = 1'b0;

    // Stall request levels shared with the stall controller.
    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // Stall vector the controller applies while EX requests a stall.
    localparam logic [5:0] STALL_EX_VEC = 6'b001111;

endpackage

// File: rtl/mdu_div_if.sv
// EX-stage <-> divider handshake bundle. master = EX requester,
// slave = divider.
interface mdu_div_if #(
    parameter int WIDTH = 32
);
    logic                 start_i;
    logic                 annul_i;
    logic                 signed_i;
    logic [WIDTH-1:0]     opa_i;
    logic [WIDTH-1:0]     opb_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 ready_o;
    logic                 stallreq_o;

    modport master (
        output start_i, annul_i, signed_i, opa_i, opb_i,
        input  result_o, ready_o, stallreq_o
    );

    modport slave (
        input  start_i, annul_i, signed_i, opa_i, opb_i,
        output result_o, ready_o, stallreq_o
    );
endinterface

// File: rtl/mdu_div_step.sv
// One restoring-division step: trial-subtract the divisor from the upper
// half of the working dividend, then shift in the quotient bit. Kept
// separate so a radix-4 variant can chain two of these.
module mdu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH:0]   dividend_i,
    input  logic [WIDTH-1:0]   divisor_i,
    output logic [2*WIDTH:0]   dividend_o
);
    logic [WIDTH:0] diff;
    // The top bit is shifted out every step and never compared.
    logic           unused_top;

    assign unused_top = dividend_i[2*WIDTH];

    // Trial subtract; a borrow means the divisor did not fit, so just shift.
    always_comb begin
        diff = {1'b0, dividend_i[2*WIDTH-1:WIDTH]} - {1'b0, divisor_i};
        if (diff[WIDTH])
            dividend_o = {dividend_i[2*WIDTH-1:0], 1'b0};
        else
            dividend_o = {diff[WIDTH-1:0], dividend_i[WIDTH-1:0], 1'b1};
    end
endmodule

// File: rtl/mdu_div.sv
// Multi-cycle signed/unsigned divider for the EX stage. Divides magnitudes
// with a restoring step per cycle and fixes signs on the final step.
// Produces {remainder, quotient} and the EX stall request.
module mdu_div
    import mdu_div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    mdu_div_if.slave    bus
);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    div_state_e          state;
    logic [CNT_W-1:0]    cnt;
    logic [2*WIDTH:0]    dividend;
    logic [WIDTH-1:0]    divisor;
    logic                sign_a;   // signed op with negative dividend
    logic                sign_b;   // signed op with negative divisor

    logic [WIDTH-1:0]    opa_abs;
    logic [WIDTH-1:0]    opb_abs;
    logic [2*WIDTH:0]    step_next;
    logic [WIDTH-1:0]    quo_fix;
    logic [WIDTH-1:0]    rem_fix;

    mdu_div_step #(.WIDTH(WIDTH)) u_step (
        .dividend_i (dividend),
        .divisor_i  (divisor),
        .dividend_o (step_next)
    );

    // Stall EX while a request is outstanding and not being flushed.
    assign bus.stallreq_o = (bus.start_i == DIV_START && bus.ready_o == DIV_NOT_READY
                             && !bus.annul_i) ? STOP : NO_STOP;

    // Operand magnitudes for the unsigned core.
    always_comb begin
        opa_abs = bus.opa_i;
        opb_abs = bus.opb_i;
        if (bus.signed_i && bus.opa_i[WIDTH-1]) opa_abs = -bus.opa_i;
        if (bus.signed_i && bus.opb_i[WIDTH-1]) opb_abs = -bus.opb_i;
    end

    // Sign fix on the final step: quotient follows sign difference,
    // remainder follows the dividend sign (truncating division).
    always_comb begin
        quo_fix = step_next[WIDTH-1:0];
        rem_fix = step_next[2*WIDTH:WIDTH+1];
        if (sign_a ^ sign_b) quo_fix = -step_next[WIDTH-1:0];
        if (sign_a)          rem_fix = -step_next[2*WIDTH:WIDTH+1];
    end

    // Divider FSM; ready/result are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            dividend     <= '0;
            divisor      <= '0;
            sign_a       <= 1'b0;
            sign_b       <= 1'b0;
            bus.ready_o  <= DIV_NOT_READY;
            bus.result_o <= '0;
        end else if (bus.annul_i) begin
            state        <= IDLE;
            cnt          <= '0;
            bus.ready_o  <= DIV_NOT_READY;
            bus.result_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_i == DIV_START) begin
                        sign_a <= bus.signed_i & bus.opa_i[WIDTH-1];
                        sign_b <= bus.signed_i & bus.opb_i[WIDTH-1];
                        if (bus.opb_i == '0) begin
                            state <= ZERO;
                        end else begin
                            state    <= RUN;
                            divisor  <= opb_abs;
                            dividend <= {{WIDTH{1'b0}}, opa_abs, 1'b0};
                            cnt      <= '0;
                        end
                    end
                end
                ZERO: begin
                    state        <= DONE;
                    bus.ready_o  <= DIV_READY;
                    bus.result_o <= '0;
                end
                RUN: begin
                    dividend <= step_next;
                    cnt      <= cnt + CNT_W'(1);
                    if (cnt == LAST_CNT) begin
                        state        <= DONE;
                        bus.ready_o  <= DIV_READY;
                        bus.result_o <= {rem_fix, quo_fix};
                    end
                end
                DONE: begin
                    // Result stays on the bus until the requester lets go.
                    if (bus.start_i == DIV_STOP) begin
                        state       <= IDLE;
                        bus.ready_o <= DIV_NOT_READY;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_div.sv
// Bench for mdu_div: table of hand-derived vectors, a few model-derived
// random vectors, and hand-written annul / reset / back-to-back sequences.
// Expected results go through a scoreboard queue.
module tb_mdu_div;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mdu_div_if #(.WIDTH(32)) bus();
    mdu_div #(.WIDTH(32), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } vec_t;

    typedef struct {
        logic [63:0] res;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[11];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one divide in the current (IDLE) cycle, hold start until ready,
    // drop it in the ready cycle and check the following cycle.
    task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] q,
                           input logic [31:0] r, input int lat);
        exp_t e;
        int   cyc;
        bit   stall_ok;
        bit   got;
        e.res = {r, q};
        e.lat = lat;
        sb_q.push_back(e);
        bus.signed_i = sgn;
        bus.opa_i    = a;
        bus.opb_i    = b;
        bus.start_i  = 1'b1;
        cyc = 0;
        stall_ok = 1'b1;
        got = 1'b0;
        while (!got && cyc < 100) begin
            #1;
            if (bus.ready_o === 1'b1) begin
                got = 1'b1;
                e = sb_q.pop_front();
                chk({name, " result"}, bus.result_o, e.res);
                chk({name, " latency"}, 64'(cyc), 64'(e.lat));
                if (bus.stallreq_o !== 1'b0) stall_ok = 1'b0;
                bus.start_i = 1'b0;
            end else begin
                if (bus.stallreq_o !== 1'b1) stall_ok = 1'b0;
                step();
                cyc++;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: no ready after %0d cycles, expected at %0d", name, cyc, lat);
            bus.start_i = 1'b0;
            if (sb_q.size() > 0) e = sb_q.pop_front();
        end
        chk({name, " stall_profile"}, 64'(stall_ok), 64'd1);
        step();
        chk({name, " ready_drop"}, 64'(bus.ready_o), 64'd0);
    endtask

    initial begin
        logic signed [31:0] sa, sb, qs, rs;
        logic [31:0] ra, rb;
        logic        rsg;
        bit          never_ready;

        tbl[0]  = '{1'b0, 32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, 32'h0000000F, 33};
        tbl[1]  = '{1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 33};
        tbl[2]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 33};
        tbl[3]  = '{1'b1, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 33};
        tbl[4]  = '{1'b0, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000, 2};
        tbl[5]  = '{1'b1, 32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000, 33};
        tbl[6]  = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
        tbl[7]  = '{1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 33};
        tbl[8]  = '{1'b0, 32'h00000005, 32'h00000007, 32'h00000000, 32'h00000005, 33};
        tbl[9]  = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 33};
        tbl[10] = '{1'b1, 32'h00000005, 32'h00000000, 32'h00000000, 32'h00000000, 2};

        rst = 1'b1;
        bus.start_i  = 1'b0;
        bus.annul_i  = 1'b0;
        bus.signed_i = 1'b0;
        bus.opa_i    = '0;
        bus.opb_i    = '0;
        repeat (3) step();
        chk("reset ready", 64'(bus.ready_o), 64'd0);
        chk("reset result", bus.result_o, 64'd0);
        chk("reset stallreq", 64'(bus.stallreq_o), 64'd0);
        // stallreq is a pure function of start/annul/ready.
        bus.start_i = 1'b1;
        #1 chk("comb stallreq start", 64'(bus.stallreq_o), 64'd1);
        bus.annul_i = 1'b1;
        #1 chk("comb stallreq annul", 64'(bus.stallreq_o), 64'd0);
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        step();
        rst = 1'b0;
        step();

        foreach (tbl[i])
            run_div($sformatf("vec%0d", i), tbl[i].sgn, tbl[i].a, tbl[i].b,
                    tbl[i].q, tbl[i].r, tbl[i].lat);

        // Random vectors against a behavioural truncating-division model.
        for (int i = 0; i < 6; i++) begin
            ra  = $urandom;
            rb  = $urandom >> $urandom_range(0, 28);
            rsg = ($urandom_range(0, 1) == 1);
            if (rb == 32'd0) rb = 32'd1;
            if (rsg && ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd3;
            if (rsg) begin
                sa = ra;
                sb = rb;
                qs = sa / sb;
                rs = sa % sb;
                run_div($sformatf("rnd%0d", i), 1'b1, ra, rb, qs, rs, 33);
            end else begin
                run_div($sformatf("rnd%0d", i), 1'b0, ra, rb, ra / rb, ra % rb, 33);
            end
        end

        // Annul mid-RUN: leaves a nonzero result beforehand so the clear is visible.
        run_div("pre_annul", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 33);
        bus.signed_i = 1'b0;
        bus.opa_i    = 32'd50;
        bus.opb_i    = 32'd5;
        bus.start_i  = 1'b1;
        never_ready  = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1 if (bus.ready_o !== 1'b0) never_ready = 1'b0;
            step();
        end
        bus.start_i = 1'b0;
        bus.annul_i = 1'b1;
        #1 chk("annul stallreq", 64'(bus.stallreq_o), 64'd0);
        step();
        bus.annul_i = 1'b0;
        if (bus.ready_o !== 1'b0) never_ready = 1'b0;
        chk("annul result_clear", bus.result_o, 64'd0);
        step();
        if (bus.ready_o !== 1'b0) never_ready = 1'b0;
        chk("annul never_ready", 64'(never_ready), 64'd1);
        run_div("annul_restart", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);

        // start together with annul in IDLE must not launch a divide.
        bus.signed_i = 1'b0;
        bus.opa_i    = 32'd17;
        bus.opb_i    = 32'd4;
        bus.start_i  = 1'b1;
        bus.annul_i  = 1'b1;
        #1 chk("start_annul stallreq", 64'(bus.stallreq_o), 64'd0);
        step();
        bus.annul_i = 1'b0;
        run_div("after_start_annul", 1'b0, 32'd17, 32'd4, 32'd4, 32'd1, 33);

        // Back-to-back divides re-entering through IDLE.
        run_div("b2b_first", 1'b0, 32'd20, 32'd3, 32'd6, 32'd2, 33);
        run_div("b2b_second", 1'b0, 32'd9, 32'd9, 32'd1, 32'd0, 33);

        // Reset in the middle of RUN.
        bus.signed_i = 1'b0;
        bus.opa_i    = 32'd77;
        bus.opb_i    = 32'd5;
        bus.start_i  = 1'b1;
        repeat (15) step();
        rst = 1'b1;
        bus.start_i = 1'b0;
        step();
        rst = 1'b0;
        chk("midrun_rst ready", 64'(bus.ready_o), 64'd0);
        chk("midrun_rst result", bus.result_o, 64'd0);
        chk("midrun_rst stallreq", 64'(bus.stallreq_o), 64'd0);
        run_div("after_rst", 1'b1, 32'd45, 32'hFFFFFFFA, 32'hFFFFFFF9, 32'd3, 33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mdu_div.md
# mdu_div

Multi-cycle 32-bit signed/unsigned integer divider in the execute stage of the 5-stage MIPS core. It is the primary source of the EX-stage stall request consumed by the pipeline stall controller. While a divide is in progress it holds the pipeline through stall vector 6'b001111. On completion it returns `{remainder, quotient}` for the HI/LO write path.

## Interface
- Parameters:
  - `WIDTH`, default 32: operand width.
  - `CNT_W`, default 6: iteration counter width; must hold the value `WIDTH`.
- `clk`  input  1: rising-edge clock.
- `rst`  input  1: reset rst, synchronous, active-high.
- `start_i`  input  1: divide request from EX. Held high until a cycle in which `ready_o`=1.
- `annul_i`  input  1: cancel the current or pending divide (flush).
- `signed_i`  input  1: 1 = DIV, 0 = DIVU. Sampled at accept.
- `opa_i`  input  WIDTH: dividend. Sampled at accept.
- `opb_i`  input  WIDTH: divisor. Sampled at accept.
- `result_o`  output  2*WIDTH: `{remainder[63:32], quotient[31:0]}`.
- `ready_o`  output  1: `result_o` valid.
- `stallreq_o`  output  1: stall request to the stall controller; combinational = `start_i & ~ready_o & ~annul_i`.

## Operation
- FSM states and transitions:
  - IDLE: if `start_i & ~annul_i`:
    - `opb_i`==0 → ZERO.
    - Otherwise → RUN. Latch the operand magnitudes: negate `opa_i`/`opb_i` when `signed_i` and MSB=1. Latch the sign flags. Set `cnt`=0 and `dividend[64:0]={32'b0, |opa|, 1'b0}`.
  - ZERO: → DONE with `result_o`=0.
  - RUN: one restoring step per cycle.
    - `diff[32:0] = {1'b0, dividend[63:32]} - {1'b0, divisor}`.
    - If `diff[32]`: `dividend <= dividend << 1`.
    - Else: `dividend <= {diff[31:0], dividend[31:0], 1'b1}`.
    - `cnt <= cnt + 1`.
    - When `cnt`==31, the step completes and the state → DONE.
  - RUN sign fix at exit:
    - Quotient = `dividend[31:0]`, negated if signed and the operand signs differ.
    - Remainder = `dividend[64:33]`, negated if signed and the dividend was negative.
  - DONE: `ready_o`=1 and `result_o` is held. If `start_i`=0 → IDLE; otherwise stay.
- `annul_i`=1 in any state → IDLE next cycle. `ready_o` is 0 next cycle. `result_o` is cleared.
- Arithmetic wraps modulo 2^32:
  - `0x80000000 / -1` signed gives quotient 0x80000000, remainder 0.
  - Divide by zero gives 0/0 and no exception.
- The requester must drop `start_i` in any cycle with `ready_o`=1. Back-to-back divides re-enter through IDLE.

## Timing
- Reset: state IDLE, `cnt`=0, `ready_o`=0, `result_o`=0, `stallreq_o` follows its combinational equation.
- Nonzero divisor, `start_i` sampled in IDLE at cycle 0:
  - RUN occupies cycles 1..32.
  - DONE is reached at cycle 33: `ready_o`=1 and `stallreq_o`=0 that cycle.
  - Total stall is 33 cycles.
- Zero divisor: ZERO at cycle 1, DONE at cycle 2.
- `result_o` and `ready_o` are registered, with no combinational path from inputs. `stallreq_o` has a combinational path from `start_i` and `annul_i`.
- `annul_i` and `start_i` asserted together: annul wins and no divide starts.
- `rst` mid-RUN: next cycle is IDLE with all outputs at their reset values.

## Structure
- The shared core macro package owns:
  - state encodings IDLE/ZERO/RUN/DONE;
  - `DIV_START`/`DIV_STOP`;
  - `DIV_READY`/`DIV_NOT_READY`.
- `STOP` is shared with the stall controller.
- One sub-module is natural: `div_step`. It is combinational, takes the 65-bit dividend and 32-bit divisor, and produces the next dividend. It isolates the subtract/shift for reuse by a future radix-4 variant.
- The sign fix stays inline in `mdu_div`.

## Test plan
- Unsigned, `opa`=0xFFFFFFFF, `opb`=0x10, `start` held → `ready_o` at cycle 33, `result_o`=`{0x0000000F, 0x0FFFFFFF}`; `stallreq_o`=1 for cycles 0..32.
- Signed, `opa`=-7 (0xFFFFFFF9), `opb`=2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- Signed, `opa`=0x80000000, `opb`=0xFFFFFFFF → quotient 0x80000000, remainder 0; `opa`=7, `opb`=-2 → quotient 0xFFFFFFFD, remainder 1.
- `opb`=0 → `ready_o` at cycle 2, `result_o`=0, `stallreq_o` high cycles 0..1 only.
- `annul_i` pulsed at cycle 10 of RUN → IDLE at cycle 11, `ready_o` never asserts; a new `start` at cycle 12 computes 100/7 → `{2, 14}` at cycle 45.
- Back-to-back: 20/3 then 9/9 with `start` dropped for one cycle after `ready_o` → results `{2, 6}` then `{0, 1}`; `rst` asserted mid-RUN → IDLE, all outputs 0 the next cycle.
